lb_readout: RTL and testbench

LB_READOUT -- requirements
Module: lb_readout

---
 rtl/alpha68k_lb_pkg.sv | 18 +
 rtl/lb_clear_sweep.sv | 58 +++++
 rtl/lb_readout.sv | 138 +++++++++++++
 tb/tb_lb_readout.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alpha68k_lb_pkg.sv
// rtl/alpha68k_lb_pkg.sv - Shared line buffer readout types, defaults and pixel field widths
package alpha68k_lb_pkg;

    localparam int LB_ACTIVE_PAIRS_DEF = 128;
    localparam int LB_DEPTH_DEF        = 256;
    localparam int ADDR_W              = 8;
    localparam int PAL_W               = 8;
    localparam int COLOR_W             = 4;
    localparam int PIX_W               = PAL_W + COLOR_W;

    typedef enum logic [1:0] {
        ST_ACTIVE_WAIT = 2'd0,
        ST_ACTIVE      = 2'd1,
        ST_SWEEP       = 2'd2,
        ST_IDLE        = 2'd3
    } lb_state_e;

endpackage

// File: rtl/lb_clear_sweep.sv
// rtl/lb_clear_sweep.sv - Read-bank pair address counter and blank-time clear sweep
module lb_clear_sweep
    import alpha68k_lb_pkg::*;
#(
    parameter int LB_DEPTH = LB_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              i_resetn,
    input  logic              i_line_start,
    input  logic              i_start,
    input  logic              i_adv,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_busy,
    output logic              o_last,
    output logic              o_err
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LB_DEPTH - 1);

    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_err;
    logic              w_last;

    assign w_last = r_busy && (r_addr == LAST_ADDR);

    // A new line wins over everything; cutting a running sweep short is flagged.
    always_ff @(posedge clk) begin
        if (!i_resetn) begin
            r_addr <= '0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (i_line_start) begin
                r_addr <= '0;
                r_busy <= 1'b0;
                r_err  <= r_busy;
            end else if (r_busy) begin
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_addr <= '0;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end else if (i_start) begin
                r_busy <= 1'b1;
            end else if (i_adv) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_busy = r_busy;
    assign o_last = w_last;
    assign o_err  = r_err;

endmodule

// File: rtl/lb_readout.sv
// rtl/lb_readout.sv - Line buffer readout: pixel pair fetch, bank swap and clear-behind
module lb_readout
    import alpha68k_lb_pkg::*;
#(
    parameter int ACTIVE_PAIRS = LB_ACTIVE_PAIRS_DEF,
    parameter int LB_DEPTH     = LB_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        CE_PIX,
    input  logic        HBLANK,
    input  logic        LINE_START,
    input  logic [11:0] E_A_DOUT,
    input  logic [11:0] E_B_DOUT,
    input  logic [11:0] O_A_DOUT,
    input  logic [11:0] O_B_DOUT,
    output logic [7:0]  LB_ADDR,
    output logic        BANK,
    output logic        nRC_E_A,
    output logic        nRC_E_B,
    output logic        nRC_O_A,
    output logic        nRC_O_B,
    output logic        nW_CLR_E_A,
    output logic        nW_CLR_E_B,
    output logic        nW_CLR_O_A,
    output logic        nW_CLR_O_B,
    output logic [11:0] PIX,
    output logic        PIX_OPAQUE,
    output logic        LB_ERR
);
    localparam logic [ADDR_W:0] END_ADDR = (ADDR_W + 1)'(ACTIVE_PAIRS);
    localparam logic            PH_EVEN  = 1'b0;
    localparam logic            PH_ODD   = 1'b1;

    lb_state_e         r_state;
    logic              r_bank;
    logic              r_phase;
    logic              r_clr_pend;
    logic [PIX_W-1:0]  r_pix;
    logic [PIX_W-1:0]  r_odd_hold;

    logic [ADDR_W-1:0] w_addr;
    logic              w_sweep_busy;
    logic              w_sweep_last;
    logic              w_err;
    logic [PIX_W-1:0]  w_even;
    logic [PIX_W-1:0]  w_odd;
    logic              w_pix_ce;
    logic              w_active_end;
    logic              w_consume;
    logic              w_adv;
    logic              w_clr;

    assign w_even       = r_bank ? E_B_DOUT : E_A_DOUT;
    assign w_odd        = r_bank ? O_B_DOUT : O_A_DOUT;
    assign w_pix_ce     = CE_PIX && !HBLANK;
    assign w_active_end = (r_state == ST_ACTIVE) && (HBLANK || ({1'b0, w_addr} == END_ADDR));
    assign w_consume    = w_pix_ce && !LINE_START && !w_active_end &&
                          ((r_state == ST_ACTIVE_WAIT) || (r_state == ST_ACTIVE));
    assign w_adv        = w_consume && (r_phase == PH_ODD);

    lb_clear_sweep #(
        .LB_DEPTH (LB_DEPTH)
    ) u_sweep (
        .clk          (clk),
        .i_resetn     (nRESET),
        .i_line_start (LINE_START),
        .i_start      (w_active_end && !LINE_START),
        .i_adv        (w_adv),
        .o_addr       (w_addr),
        .o_busy       (w_sweep_busy),
        .o_last       (w_sweep_last),
        .o_err        (w_err)
    );

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            r_state    <= ST_IDLE;
            r_bank     <= 1'b0;
            r_phase    <= PH_EVEN;
            r_clr_pend <= 1'b0;
            r_pix      <= '0;
            r_odd_hold <= '0;
        end else begin
            r_clr_pend <= 1'b0;
            if (LINE_START) begin
                r_bank  <= ~r_bank;
                r_phase <= PH_EVEN;
                r_state <= ST_ACTIVE_WAIT;
            end else begin
                case (r_state)
                    ST_ACTIVE_WAIT, ST_ACTIVE: begin
                        if (w_active_end) begin
                            r_pix   <= '0;
                            r_state <= ST_SWEEP;
                        end else if (w_consume) begin
                            r_state <= ST_ACTIVE;
                            // The even fetch empties the pair, so clear it right behind the read.
                            if (r_phase == PH_EVEN) begin
                                r_pix      <= w_even;
                                r_odd_hold <= w_odd;
                                r_phase    <= PH_ODD;
                                r_clr_pend <= 1'b1;
                            end else begin
                                r_pix   <= r_odd_hold;
                                r_phase <= PH_EVEN;
                            end
                        end
                    end
                    ST_SWEEP: begin
                        if (w_sweep_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign w_clr = r_clr_pend || w_sweep_busy;

    assign LB_ADDR    = w_addr;
    assign BANK       = r_bank;
    assign nRC_E_A    = ~r_bank;
    assign nRC_O_A    = ~r_bank;
    assign nRC_E_B    = r_bank;
    assign nRC_O_B    = r_bank;
    assign nW_CLR_E_A = ~(w_clr && !r_bank);
    assign nW_CLR_O_A = ~(w_clr && !r_bank);
    assign nW_CLR_E_B = ~(w_clr && r_bank);
    assign nW_CLR_O_B = ~(w_clr && r_bank);
    assign PIX        = HBLANK ? '0 : r_pix;
    assign PIX_OPAQUE = (PIX[COLOR_W-1:0] != '0);
    assign LB_ERR     = w_err;

endmodule

// File: tb/tb_lb_readout.sv
// tb/tb_lb_readout.sv - Scoreboard bench for lb_readout
module tb_lb_readout;
    import alpha68k_lb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nreset, ce_pix, hblank, line_start;
    logic [11:0] e_a_dout, e_b_dout, o_a_dout, o_b_dout;
    logic [7:0]  lb_addr;
    logic        bank, nrc_e_a, nrc_e_b, nrc_o_a, nrc_o_b;
    logic        nw_clr_e_a, nw_clr_e_b, nw_clr_o_a, nw_clr_o_b;
    logic [11:0] pix;
    logic        pix_opaque, lb_err;

    lb_readout dut (
        .clk(clk), .nRESET(nreset), .CE_PIX(ce_pix), .HBLANK(hblank), .LINE_START(line_start),
        .E_A_DOUT(e_a_dout), .E_B_DOUT(e_b_dout), .O_A_DOUT(o_a_dout), .O_B_DOUT(o_b_dout),
        .LB_ADDR(lb_addr), .BANK(bank),
        .nRC_E_A(nrc_e_a), .nRC_E_B(nrc_e_b), .nRC_O_A(nrc_o_a), .nRC_O_B(nrc_o_b),
        .nW_CLR_E_A(nw_clr_e_a), .nW_CLR_E_B(nw_clr_e_b),
        .nW_CLR_O_A(nw_clr_o_a), .nW_CLR_O_B(nw_clr_o_b),
        .PIX(pix), .PIX_OPAQUE(pix_opaque), .LB_ERR(lb_err)
    );

    logic [11:0] mem_e [2][256];
    logic [11:0] mem_o [2][256];

    always @(posedge clk) begin
        e_a_dout <= mem_e[0][lb_addr];
        o_a_dout <= mem_o[0][lb_addr];
        e_b_dout <= mem_e[1][lb_addr];
        o_b_dout <= mem_o[1][lb_addr];
    end

    int n_cmp = 0, n_err = 0;
    int clr_a = 0, clr_b = 0, clr_any = 0, wb_viol = 0, pair_viol = 0;
    logic [7:0] last_clr_addr = 8'h00;

    always @(posedge clk) begin
        #2;
        if (!nw_clr_e_a || !nw_clr_o_a) clr_a++;
        if (!nw_clr_e_b || !nw_clr_o_b) clr_b++;
        if (!(nw_clr_e_a && nw_clr_o_a && nw_clr_e_b && nw_clr_o_b)) begin
            clr_any++;
            last_clr_addr = lb_addr;
        end
        if ((nw_clr_e_a != nw_clr_o_a) || (nw_clr_e_b != nw_clr_o_b)) pair_viol++;
        if (bank ? !(nw_clr_e_a && nw_clr_o_a) : !(nw_clr_e_b && nw_clr_o_b)) wb_viol++;
    end

    logic        exp_bank = 1'b0;
    logic [7:0]  exp_addr = 8'h00;
    logic        exp_phase = 1'b0;
    logic [11:0] exp_odd = 12'h000;
    logic [11:0] sb [$];

    task automatic do_line_start();
        @(negedge clk) line_start = 1'b1;
        @(negedge clk) line_start = 1'b0;
        exp_bank  = ~exp_bank;
        exp_addr  = 8'h00;
        exp_phase = 1'b0;
    endtask

    task automatic pix_ce();
        logic [11:0] e;
        if (!exp_phase) begin
            sb.push_back(mem_e[exp_bank][exp_addr]);
            exp_odd = mem_o[exp_bank][exp_addr];
        end else begin
            sb.push_back(exp_odd);
        end
        @(negedge clk) ce_pix = 1'b1;
        @(negedge clk) ce_pix = 1'b0;
        if (exp_phase) exp_addr = exp_addr + 8'd1;
        exp_phase = ~exp_phase;
        e = sb.pop_front();
        n_cmp++; if (pix !== e) begin n_err++; $display("FAIL pix: got %h expected %h", pix, e); end
        n_cmp++; if (lb_addr !== exp_addr) begin n_err++; $display("FAIL lb_addr: got %h expected %h", lb_addr, exp_addr); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        nreset = 1'b0; ce_pix = 1'b0; hblank = 1'b1; line_start = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) begin
                mem_e[b][i] = 12'((b << 11) ^ (i * 37));
                mem_o[b][i] = 12'((b << 11) ^ (i * 53) ^ 12'h5A5);
            end
        repeat (3) @(negedge clk);
        n_cmp++; if (bank !== 1'b0) begin n_err++; $display("FAIL rst_bank: got %b expected 0", bank); end
        n_cmp++; if (lb_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %h expected 00", lb_addr); end
        n_cmp++; if (dut.r_pix !== 12'h000) begin n_err++; $display("FAIL rst_pix: got %h expected 000", dut.r_pix); end
        n_cmp++; if ({nw_clr_e_a, nw_clr_o_a, nw_clr_e_b, nw_clr_o_b} !== 4'b1111) begin
            n_err++; $display("FAIL rst_clr: got %b expected 1111", {nw_clr_e_a, nw_clr_o_a, nw_clr_e_b, nw_clr_o_b}); end
        n_cmp++; if ({nrc_e_a, nrc_o_a, nrc_e_b, nrc_o_b} !== 4'b1100) begin
            n_err++; $display("FAIL rst_nrc: got %b expected 1100", {nrc_e_a, nrc_o_a, nrc_e_b, nrc_o_b}); end
        n_cmp++; if (lb_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b expected 0", lb_err); end
        n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d expected %0d", dut.r_state, ST_IDLE); end
        nreset = 1'b1;
        exp_bank = 1'b0;
    endtask

    task automatic test_first_pair();
        int ca, cb;
        do_line_start();
        mem_e[0][0] = 12'h123; mem_o[0][0] = 12'h456;
        mem_e[1][0] = 12'h123; mem_o[1][0] = 12'h456;
        hblank = 1'b0;
        ca = clr_a; cb = clr_b;
        pix_ce();
        n_cmp++; if (clr_b - cb !== 1) begin n_err++; $display("FAIL first_clr_read: got %0d expected 1", clr_b - cb); end
        n_cmp++; if (clr_a - ca !== 0) begin n_err++; $display("FAIL first_clr_write: got %0d expected 0", clr_a - ca); end
        n_cmp++; if (last_clr_addr !== 8'h00) begin n_err++; $display("FAIL first_clr_addr: got %h expected 00", last_clr_addr); end
        pix_ce();
        n_cmp++; if (bank !== 1'b1) begin n_err++; $display("FAIL first_bank: got %b expected 1", bank); end
        n_cmp++; if ({nrc_e_a, nrc_o_a, nrc_e_b, nrc_o_b} !== 4'b0011) begin
            n_err++; $display("FAIL first_nrc: got %b expected 0011", {nrc_e_a, nrc_o_a, nrc_e_b, nrc_o_b}); end
    endtask

    task automatic test_full_line();
        int base;
        do_line_start();
        for (int i = 0; i < 256; i++) begin
            mem_e[exp_bank][i] = 12'(12'h100 + 2 * i);
            mem_o[exp_bank][i] = 12'(12'h101 + 2 * i);
        end
        hblank = 1'b0;
        base = clr_any;
        for (int p = 0; p < 256; p++) pix_ce();
        repeat (140) @(negedge clk);
        hblank = 1'b1;
        n_cmp++; if (clr_any - base !== 256) begin n_err++; $display("FAIL line_clr_count: got %0d expected 256", clr_any - base); end
        n_cmp++; if (last_clr_addr !== 8'hFF) begin n_err++; $display("FAIL line_clr_last: got %h expected ff", last_clr_addr); end
        n_cmp++; if (lb_addr !== 8'h00) begin n_err++; $display("FAIL line_end_addr: got %h expected 00", lb_addr); end
        n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL line_state: got %0d expected %0d", dut.r_state, ST_IDLE); end
        n_cmp++; if (dut.r_pix !== 12'h000) begin n_err++; $display("FAIL line_pix: got %h expected 000", dut.r_pix); end
    endtask

    task automatic test_sweep_abort();
        int base;
        do_line_start();
        hblank = 1'b0;
        repeat (4) pix_ce();
        hblank = 1'b1;
        base = clr_any;
        repeat (20) @(negedge clk);
        n_cmp++; if (clr_any - base !== 20) begin n_err++; $display("FAIL abort_pre_count: got %0d expected 20", clr_any - base); end
        n_cmp++; if (last_clr_addr !== 8'h15) begin n_err++; $display("FAIL abort_pre_addr: got %h expected 15", last_clr_addr); end
        line_start = 1'b1;
        @(negedge clk) line_start = 1'b0;
        exp_bank = ~exp_bank; exp_addr = 8'h00; exp_phase = 1'b0;
        n_cmp++; if (lb_err !== 1'b1) begin n_err++; $display("FAIL abort_err: got %b expected 1", lb_err); end
        n_cmp++; if (bank !== exp_bank) begin n_err++; $display("FAIL abort_bank: got %b expected %b", bank, exp_bank); end
        n_cmp++; if (lb_addr !== 8'h00) begin n_err++; $display("FAIL abort_addr: got %h expected 00", lb_addr); end
        @(negedge clk);
        n_cmp++; if (lb_err !== 1'b0) begin n_err++; $display("FAIL abort_err_len: got %b expected 0", lb_err); end
        repeat (10) @(negedge clk);
        n_cmp++; if (clr_any - base !== 20) begin n_err++; $display("FAIL abort_post_count: got %0d expected 20", clr_any - base); end
    endtask

    task automatic test_ls_ce_same();
        int base;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 2; i++) begin
                mem_e[b][i] = 12'(12'h200 + 16 * b + 2 * i);
                mem_o[b][i] = 12'(12'h201 + 16 * b + 2 * i);
            end
        do_line_start();
        hblank = 1'b0;
        repeat (2) pix_ce();
        @(negedge clk) begin line_start = 1'b1; ce_pix = 1'b1; end
        @(negedge clk) begin line_start = 1'b0; ce_pix = 1'b0; end
        exp_bank = ~exp_bank; exp_addr = 8'h00; exp_phase = 1'b0;
        base = clr_any;
        n_cmp++; if (lb_addr !== 8'h00) begin n_err++; $display("FAIL lsce_addr: got %h expected 00", lb_addr); end
        n_cmp++; if (bank !== exp_bank) begin n_err++; $display("FAIL lsce_bank: got %b expected %b", bank, exp_bank); end
        repeat (3) @(negedge clk);
        n_cmp++; if (clr_any - base !== 0) begin n_err++; $display("FAIL lsce_clr: got %0d expected 0", clr_any - base); end
        repeat (2) pix_ce();
    endtask

    task automatic test_reset_mid_line();
        int base;
        do_line_start();
        hblank = 1'b0;
        repeat (128) pix_ce();
        @(negedge clk) begin nreset = 1'b0; ce_pix = 1'b1; end
        base = clr_any;
        @(negedge clk) ce_pix = 1'b0;
        n_cmp++; if ({bank, lb_addr} !== 9'h000) begin n_err++; $display("FAIL rmid_bank_addr: got %h expected 000", {bank, lb_addr}); end
        n_cmp++; if (pix !== 12'h000) begin n_err++; $display("FAIL rmid_pix: got %h expected 000", pix); end
        n_cmp++; if (lb_err !== 1'b0) begin n_err++; $display("FAIL rmid_err: got %b expected 0", lb_err); end
        repeat (4) @(negedge clk);
        n_cmp++; if (clr_any - base !== 0) begin n_err++; $display("FAIL rmid_clr: got %0d expected 0", clr_any - base); end
        nreset = 1'b1;
        exp_bank = 1'b0; exp_addr = 8'h00; exp_phase = 1'b0;
        do_line_start();
        repeat (2) pix_ce();
    endtask

    task automatic test_opaque();
        hblank = 1'b1;
        do_line_start();
        mem_e[exp_bank][0] = 12'h7F0; mem_o[exp_bank][0] = 12'h7F1;
        @(negedge clk) ce_pix = 1'b1;
        @(negedge clk) ce_pix = 1'b0;
        n_cmp++; if (lb_addr !== 8'h00) begin n_err++; $display("FAIL blank_addr: got %h expected 00", lb_addr); end
        n_cmp++; if (pix !== 12'h000) begin n_err++; $display("FAIL blank_pix: got %h expected 000", pix); end
        repeat (3) @(negedge clk);
        hblank = 1'b0;
        pix_ce();
        n_cmp++; if (pix_opaque !== 1'b0) begin n_err++; $display("FAIL opaque_7f0: got %b expected 0", pix_opaque); end
        pix_ce();
        n_cmp++; if (pix_opaque !== 1'b1) begin n_err++; $display("FAIL opaque_7f1: got %b expected 1", pix_opaque); end
        n_cmp++; if (wb_viol !== 0) begin n_err++; $display("FAIL write_bank_clr: got %0d expected 0", wb_viol); end
        n_cmp++; if (pair_viol !== 0) begin n_err++; $display("FAIL clr_pairing: got %0d expected 0", pair_viol); end
    endtask

    initial begin
        test_reset();
        test_first_pair();
        test_full_line();
        test_sweep_abort();
        test_ls_ce_same();
        test_reset_mid_line();
        test_opaque();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
